// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
// DEF_WIDTH/DEF_GROUP : default operand width and lookahead group size.
// ngroups()           : number of lookahead groups for a WIDTH/GROUP pair.
// cfg_ok()            : legal WIDTH/GROUP combination (used at elaboration).
package cla_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_GROUP = 4;

  function automatic int ngroups(input int width, input int group);
    return width / group;
  endfunction

  function automatic bit cfg_ok(input int width, input int group);
    return (group >= 2) && (group <= 8) && (width >= group) && (width % group == 0);
  endfunction
endpackage

// File: rtl/cla_adder_pipe_if.sv
// Operand/result handshake bundle for cla_adder_pipe.
// master: producer of operands and consumer of results (ALU / bench).
// slave : the adder.
// With CLA_SUB_EN defined, an extra 'sub' operand bit selects x-y.
interface cla_adder_pipe_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
`ifdef CLA_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, x, y, cin,
`ifdef CLA_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, x, y, cin,
`ifdef CLA_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_group.sv
// One GROUP-bit lookahead group (purely combinational).
// g, p : per-bit generate/propagate
// ci   : carry into the group's LSB
// c    : carry into each bit of the group
// gg   : group generate (independent of ci)
// pg   : group propagate (AND of all bit propagates)
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] g,
  input  logic [GROUP-1:0] p,
  input  logic             ci,
  output logic [GROUP-1:0] c,
  output logic             gg,
  output logic             pg
);
  always_comb begin
    logic cc;
    c  = '0;
    cc = ci;
    gg = 1'b0;
    pg = 1'b1;
    for (int i = 0; i < GROUP; i++) begin
      c[i] = cc;
      cc   = g[i] | (p[i] & cc);
      gg   = g[i] | (p[i] & gg);
      pg   = pg & p[i];
    end
  end
endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake.
// clk   : rising-edge clock
// rst_n : synchronous active-low reset
// bus   : cla_adder_pipe_if.slave (operands in, sum/cout/ovf out)
// Stage 1 registers operands plus bit and group generate/propagate;
// stage 2 resolves group carries, ripples them into each group and
// registers sum/cout/ovf. Capacity is two results.
// Optional: CLA_SUB_EN adds bus.sub for x-y (~y with forced carry-in).
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input  logic clk,
  input  logic rst_n,
  cla_adder_pipe_if.slave bus
);
  localparam int NG = ngroups(WIDTH, GROUP);

  if (!cfg_ok(WIDTH, GROUP)) begin : g_cfg_err
    $error("cla_adder_pipe: WIDTH must be a multiple of GROUP, GROUP in 2..8");
  end

  // ---------------- handshake ----------------
  logic s1_valid, out_valid;
  logic s2_free, s1_adv, accept;

  assign s2_free       = !out_valid | bus.out_ready;
  assign s1_adv        = s1_valid & s2_free;
  assign bus.in_ready  = !s1_valid | s2_free;
  assign accept        = bus.in_valid & bus.in_ready;

  // ---------------- stage 1 ----------------
  logic [WIDTH-1:0] y_e, g1, p1;
  logic             cin_e;

  always_comb begin
    y_e   = bus.y;
    cin_e = bus.cin;
`ifdef CLA_SUB_EN
    if (bus.sub) begin
      y_e   = ~bus.y;
      cin_e = 1'b1;
    end
`endif
    g1 = bus.x & y_e;
    p1 = bus.x | y_e;
  end

  logic [NG-1:0]            G1, P1;
  logic [NG-1:0][GROUP-1:0] s1_c_unused;

  for (genvar k = 0; k < NG; k++) begin : g_s1_grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .g  (g1[k*GROUP +: GROUP]),
      .p  (p1[k*GROUP +: GROUP]),
      .ci (1'b0),
      .c  (s1_c_unused[k]),
      .gg (G1[k]),
      .pg (P1[k])
    );
  end

  logic [WIDTH-1:0] s1_x, s1_y, s1_g, s1_p;
  logic [NG-1:0]    s1_G, s1_P;
  logic             s1_cin;

  // Operand registers carry no reset: s1_valid qualifies them.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_x   <= bus.x;
      s1_y   <= y_e;
      s1_cin <= cin_e;
      s1_g   <= g1;
      s1_p   <= p1;
      s1_G   <= G1;
      s1_P   <= P1;
    end
  end

  // ---------------- stage 2 ----------------
  logic [NG:0]              gc;
  logic [NG-1:0][GROUP-1:0] bc;
  logic [NG-1:0]            s2_g_unused, s2_p_unused;

  // Second-level lookahead across groups.
  always_comb begin
    gc    = '0;
    gc[0] = s1_cin;
    for (int k = 0; k < NG; k++)
      gc[k+1] = s1_G[k] | (s1_P[k] & gc[k]);
  end

  for (genvar k = 0; k < NG; k++) begin : g_s2_grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .g  (s1_g[k*GROUP +: GROUP]),
      .p  (s1_p[k*GROUP +: GROUP]),
      .ci (gc[k]),
      .c  (bc[k]),
      .gg (s2_g_unused[k]),
      .pg (s2_p_unused[k])
    );
  end

  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (accept)      s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;

      if (s1_adv) begin
        out_valid <= 1'b1;
        sum_q     <= s1_x ^ s1_y ^ bc;
        cout_q    <= gc[NG];
        ovf_q     <= bc[NG-1][GROUP-1] ^ gc[NG];
      end else if (bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: doc/cla_adder_pipe.md
Name: cla_adder_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder for the ALU datapath.
- Generalises the fixed 3-bit carry logic to WIDTH bits built from GROUP-bit lookahead groups, with a second-level lookahead across groups.
- Two register stages with a valid/ready handshake, so the ALU can stall the adder without losing operands.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of GROUP.
- GROUP, 4, bits per lookahead group; range 2..8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  operands presented
- in_ready  output  1  adder accepts operands this cycle
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B
- cin  input  1  carry in
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  x+y+cin, truncated to WIDTH
- cout  output  1  carry out of MSB
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- One clock; reset is synchronous and active-low: all state updates on rising clk; rst_n=0 sampled at an edge clears state.
- Reset values: s1_valid=0, out_valid=0, sum=0, cout=0, ovf=0.
- Bit-level terms: g=x&y, p=x|y; both are bitwise single-bit AND/OR.
- Stage 1, on accept (in_valid & in_ready):
  - Per group: group generate G and propagate P (P = AND of bit p; G via the standard lookahead recurrence).
  - Register x, y, cin, per-bit g/p, and group G/P. Set s1_valid=1.
- Stage 2, on advance:
  - Group carry-ins: c[0]=cin; c[k+1]=G[k] | (P[k] & c[k]).
  - In-group carries use the same recurrence at bit level.
  - sum[i] = x[i]^y[i]^carry_in[i]; cout = carry out of bit WIDTH-1; ovf = carry_in[WIDTH-1] ^ cout.
  - Register results; set out_valid=1.
- Handshake:
  - s2_free = !out_valid | out_ready.
  - s1 advances when s1_valid & s2_free.
  - in_ready = !s1_valid | s2_free.
  - in_ready may depend combinationally on out_ready; no other combinational in-to-out paths.
- Latency: result valid 2 cycles after accept; throughput 1/cycle when out_ready=1.
- Ordering: results emerge in accept order; none dropped or duplicated.
- Stall: with out_valid=1 & out_ready=0, sum/cout/ovf/out_valid hold stable.
  - s1 holds its contents if full; in_ready=0 once both stages are full (capacity 2).
- Drain: if s1 is empty while stage 2 is consumed, out_valid falls to 0 next cycle.
- Simultaneous consume and accept: both occur in the same cycle; no bubble inserted.
- Reset mid-operation: all in-flight results discarded; out_valid=0 the cycle after the reset edge.
- x, y and cin are don't-care when in_valid=0.

Optional Feature:
- CLA_SUB_EN defined:
  - Adds input port sub (1 bit), sampled with operands on accept.
  - When sub=1, stage 1 uses ~y and forces effective cin=1, giving x-y.
  - cout then means no-borrow; ovf is the signed-subtract overflow.
- CLA_SUB_EN undefined: no sub port; add only; behaviour exactly as above.

Decomposition:
- Shared package/include cla_pkg:
  - Default WIDTH/GROUP constants.
  - Function computing NGROUPS=WIDTH/GROUP.
  - Elaboration-time check that WIDTH % GROUP == 0.
- Sub-module cla_group (combinational, GROUP-bit):
  - Inputs: g/p bits, carry-in.
  - Outputs: per-bit carries, G, P.
  - Instantiated NGROUPS times in stage 2, and its G/P outputs reused in stage 1.
- Top module holds pipeline registers and handshake.

Test Plan:
1. WIDTH=16: x=0xFFFF, y=0x0001, cin=0, out_ready=1 -> 2 cycles later sum=0x0000, cout=1, ovf=0, out_valid pulses 1 cycle.
2. x=0x7FFF, y=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; x=0x1234, y=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0.
3. Three back-to-back accepts (0+1, 2+3, 0xFFF0+0x0020), out_ready=1 -> results 0x0001, 0x0005, then 0x0010 with cout=1, on 3 consecutive cycles.
4. out_ready=0, offer 3 ops -> first 2 accepted, in_ready=0 on 3rd; outputs stable; raise out_ready -> 3rd accepted same cycle, order preserved.
5. Both stages full, rst_n=0 for 1 cycle -> out_valid=0 and sum=0 next cycle; neither stalled result ever appears.
6. CLA_SUB_EN: sub=1, x=0x0005, y=0x0007 -> sum=0xFFFE, cout=0; x=0x8000, y=0x0001 -> sum=0x7FFF, ovf=1, cout=1.
